// File: rtl/data_reader.sv
// ---------------------------------------------------------------------------
// data_reader : 2**AW x DW store with a valid/ready streaming read port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_reader #(
  parameter int AW = 2,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_start,
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] rd_len,
  output logic          busy,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] rd_ptr,
  output logic          rd_last
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] store [DEPTH];
  logic [AW-1:0] remaining, remaining_next;
  logic [AW-1:0] ptr_next, ptr_inc;
  logic [DW-1:0] data_next;
  logic          last_next;

  // Reads in the next-state logic see pre-write contents because the
  // store only updates on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (wr_en) begin
      store[wr_addr] <= wr_data;
    end
  end

  assign ptr_inc = rd_ptr + AW'(1);

  always_comb begin
    state_next     = state;
    ptr_next       = rd_ptr;
    data_next      = rd_data;
    remaining_next = remaining;
    last_next      = rd_last;
    case (state)
      IDLE: begin
        if (rd_start) begin
          state_next     = STREAM;
          ptr_next       = rd_addr;
          data_next      = store[rd_addr];
          remaining_next = rd_len;
          last_next      = (rd_len == '0);
        end
      end
      STREAM: begin
        if (rd_ready) begin
          if (rd_last) begin
            state_next = IDLE;
            last_next  = 1'b0;
          end else begin
            ptr_next       = ptr_inc;
            data_next      = store[ptr_inc];
            remaining_next = remaining - AW'(1);
            last_next      = (remaining == AW'(1));
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      rd_data   <= '0;
      remaining <= '0;
      rd_last   <= 1'b0;
    end else begin
      state     <= state_next;
      rd_ptr    <= ptr_next;
      rd_data   <= data_next;
      remaining <= remaining_next;
      rd_last   <= last_next;
    end
  end

  assign busy     = (state == STREAM);
  assign rd_valid = (state == STREAM);

endmodule

`default_nettype wire

// File: tb/tb_data_reader.sv
// ---------------------------------------------------------------------------
// tb_data_reader : directed self-checking bench for data_reader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr, wr_data;
  logic       rd_start;
  logic [1:0] rd_addr, rd_len;
  logic       busy, rd_valid, rd_ready, rd_last;
  logic [1:0] rd_data, rd_ptr;

  int checks   = 0;
  int failures = 0;

  data_reader #(.AW(2), .DW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_start (rd_start),
    .rd_addr  (rd_addr),
    .rd_len   (rd_len),
    .busy     (busy),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_ptr   (rd_ptr),
    .rd_last  (rd_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks {valid, busy, last, ptr, data} as one packed word.
  task automatic chk_out(input string tag, input logic v, input logic [1:0] p,
                         input logic [1:0] d, input logic l);
    chk(tag, {1'b0, rd_valid, busy, rd_last, rd_ptr, rd_data},
             {1'b0, v, v, l, p, d});
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start(input logic [1:0] a, input logic [1:0] n);
    rd_start = 1'b1; rd_addr = a; rd_len = n;
    tick();
    rd_start = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_basic [4];
    logic [1:0] exp_after [4];
    exp_basic = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_after = '{2'd1, 2'd3, 2'd3, 2'd0};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_start = 1'b0; rd_addr = '0; rd_len = '0; rd_ready = 1'b0;
    tick(); tick();
    chk_out("reset_hold", 1'b0, 2'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("idle_after_reset", 1'b0, 2'd0, 2'd0, 1'b0);

    // 1-word read of address 2 from a freshly reset store
    start(2'd2, 2'd0);
    chk_out("rd2_first", 1'b1, 2'd2, 2'd0, 1'b1);
    rd_ready = 1'b1;
    tick();
    chk_out("rd2_done", 1'b0, 2'd2, 2'd0, 1'b0);
    rd_ready = 1'b0;

    // Basic 4-word stream at full rate
    wr(2'd0, 2'd1); wr(2'd1, 2'd2); wr(2'd2, 2'd3); wr(2'd3, 2'd0);
    rd_ready = 1'b1;
    start(2'd0, 2'd3);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("basic_w%0d", i), 1'b1, 2'(i), exp_basic[i], i == 3);
      tick();
    end
    chk_out("basic_end", 1'b0, 2'd3, 2'd0, 1'b0);

    // Wrap 3 -> 0 with 3 cycles of backpressure
    rd_ready = 1'b0;
    start(2'd3, 2'd1);
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("bp_hold%0d", i), 1'b1, 2'd3, 2'd0, 1'b0);
      tick();
    end
    chk_out("bp_hold3", 1'b1, 2'd3, 2'd0, 1'b0);
    rd_ready = 1'b1;
    tick();
    chk_out("wrap_w1", 1'b1, 2'd0, 2'd1, 1'b1);
    tick();
    chk_out("wrap_end", 1'b0, 2'd0, 2'd1, 1'b0);
    rd_ready = 1'b0;

    // Start and write to the same address on the same edge
    rd_start = 1'b1; rd_addr = 2'd1; rd_len = 2'd0;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 2'd3;
    tick();
    rd_start = 1'b0; wr_en = 1'b0;
    chk_out("coll_old", 1'b1, 2'd1, 2'd2, 1'b1);
    rd_ready = 1'b1;
    tick();
    chk_out("coll_end", 1'b0, 2'd1, 2'd2, 1'b0);
    rd_ready = 1'b0;
    start(2'd1, 2'd0);
    chk_out("coll_new", 1'b1, 2'd1, 2'd3, 1'b1);
    rd_ready = 1'b1;
    tick();
    chk_out("coll_new_end", 1'b0, 2'd1, 2'd3, 1'b0);

    // rd_start held high through a whole stream, including the final edge
    start(2'd0, 2'd3);
    rd_start = 1'b1; rd_addr = 2'd2; rd_len = 2'd0;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("ign_w%0d", i), 1'b1, 2'(i), exp_after[i], i == 3);
      tick();
    end
    rd_start = 1'b0;
    chk_out("ign_end", 1'b0, 2'd3, 2'd0, 1'b0);
    tick();
    chk_out("ign_no_restart", 1'b0, 2'd3, 2'd0, 1'b0);

    // Asynchronous reset in the middle of a stream
    start(2'd0, 2'd3);
    chk_out("mr_w0", 1'b1, 2'd0, 2'd1, 1'b0);
    tick();
    chk_out("mr_w1", 1'b1, 2'd1, 2'd3, 1'b0);
    tick();
    chk_out("mr_w2", 1'b1, 2'd2, 2'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async", {6'd0, rd_valid, busy}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_out("mr_after", 1'b0, 2'd0, 2'd0, 1'b0);
    rd_ready = 1'b1;
    start(2'd0, 2'd3);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("mr_zero%0d", i), 1'b1, 2'(i), 2'd0, i == 3);
      tick();
    end
    chk_out("mr_end", 1'b0, 2'd3, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_reader.md
Name: data_reader

Overview:
- Read-side companion to the 2-bit processor's data write logic.
- Holds a 4-word x 2-bit data store that the write side fills through a simple strobe port.
- Streams a contiguous run of words out to a consumer over a valid/ready handshake.
- The run has a programmable start address and length, and wraps from the top address back to 0.

Parameters:
- AW, 2, address width; store depth is 2**AW words.
- DW, 2, data word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe; stores wr_data at wr_addr on the clock edge.
- wr_addr  input  AW  write address.
- wr_data  input  DW  write data.
- rd_start  input  1  request to begin a read stream; sampled only in IDLE.
- rd_addr  input  AW  first address of the stream; sampled with rd_start.
- rd_len  input  AW  stream length minus one (0 = 1 word, 3 = 4 words); sampled with rd_start.
- busy  output  1  high while a stream is in progress (STREAM state).
- rd_valid  output  1  rd_data, rd_last and rd_ptr are valid.
- rd_ready  input  1  consumer accepts the current word.
- rd_data  output  DW  current stream word.
- rd_ptr  output  AW  address of the current word.
- rd_last  output  1  current word is the final word of the stream.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all store words = 0; FSM = IDLE.
  - busy = 0, rd_valid = 0, rd_data = 0, rd_ptr = 0, rd_last = 0; internal remaining-count = 0.
  - Reset asserted mid-stream aborts the stream immediately; no partial handshake completes.
- Store:
  - wr_en writes in any state.
  - Same-edge read of the written address returns the OLD contents (read-before-write).
- FSM states: IDLE, STREAM.
- IDLE:
  - rd_start high at edge N moves to STREAM at edge N.
  - Outputs after edge N: rd_valid = 1, busy = 1, rd_ptr = rd_addr, rd_data = store[rd_addr] (pre-write value), remaining = rd_len, rd_last = (rd_len == 0).
  - Latency from rd_start to first valid word: 1 cycle.
- STREAM:
  - rd_valid stays high.
  - rd_data, rd_ptr and rd_last hold stable while rd_ready is low. Later writes to rd_ptr do not alter a word already presented.
  - Transfer = rd_valid & rd_ready at an edge.
  - Transfer with rd_last = 1: next state IDLE; rd_valid, busy and rd_last go 0; rd_data and rd_ptr hold their last values.
  - Transfer with rd_last = 0:
    - rd_ptr <= rd_ptr + 1 mod 2**AW (3 wraps to 0).
    - rd_data <= store[rd_ptr + 1] (pre-write value).
    - remaining <= remaining - 1.
    - rd_last <= (remaining - 1 == 0).
  - Back-to-back transfers sustain 1 word per cycle.
  - rd_start in STREAM is ignored, including on the final-transfer edge; a new stream needs rd_start in a cycle where the FSM is in IDLE.
- rd_len = 3 starting at any address reads all 4 words exactly once, in wrap order.
- No X on any output after reset release.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low 2 cycles, release, no requests.
  - Required: all outputs 0; a 1-word read of addr 2 returns 0.
- Basic stream:
  - Stimulus: write store = {0:1, 1:2, 2:3, 3:0}; rd_start with rd_addr = 0, rd_len = 3; rd_ready held 1.
  - Required: rd_data 1, 2, 3, 0 on 4 consecutive cycles; rd_last only on the 4th; busy drops the next cycle.
- Wrap plus backpressure:
  - Stimulus: same store; rd_addr = 3, rd_len = 1; rd_ready low 3 cycles, then high.
  - Required: rd_data = 0 with rd_ptr = 3 held stable 3 cycles; then rd_data = 1, rd_ptr = 0, rd_last = 1; then idle.
- Write collision:
  - Stimulus: rd_start with rd_addr = 1, plus wr_en to addr 1 with value 3 on the same edge (old value 2).
  - Required: first word = 2; a subsequent 1-word read of addr 1 returns 3.
- Ignored start:
  - Stimulus: rd_start pulsed during an active 4-word stream, including on the final-transfer edge.
  - Required: the stream is unchanged; FSM returns to IDLE; no second stream begins.
- Mid-stream reset:
  - Stimulus: rst_n low for 1 cycle after the 2nd of 4 words.
  - Required: rd_valid and busy go 0 immediately (asynchronously); store reads back all zeros.
